// File: rtl/user_id_pkg.sv
// Shared types and default sizing for the user project ID reader path.
package user_id_pkg;

  localparam int DEFAULT_ID_WIDTH   = 32;
  localparam int DEFAULT_SHIFT_DIV  = 4;
  localparam int DEFAULT_SAMPLE_GAP = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GAP   = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/user_id_reader_if.sv
// Read request, parallel ID result and serial readback bundle of the ID reader.
interface user_id_reader_if #(
  parameter int ID_WIDTH = 32
) ();

  logic                req_i;
  logic                busy_o;
  logic                id_valid_o;
  logic [ID_WIDTH-1:0] id_data_o;
  logic                id_mismatch_o;
  logic                ser_data_o;
  logic                ser_strobe_o;
  logic                ser_last_o;

  modport master (
    output req_i,
    input  busy_o, id_valid_o, id_data_o, id_mismatch_o,
    input  ser_data_o, ser_strobe_o, ser_last_o
  );

  modport slave (
    input  req_i,
    output busy_o, id_valid_o, id_data_o, id_mismatch_o,
    output ser_data_o, ser_strobe_o, ser_last_o
  );

endinterface

// File: rtl/user_id_serializer.sv
// MSB-first shifter: one bit per SHIFT_DIV clocks while active, last flags the final bit.
module user_id_serializer #(
  parameter int ID_WIDTH  = 32,
  parameter int SHIFT_DIV = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [ID_WIDTH-1:0] load_data_i,
  input  logic                active_i,
  output logic                ser_data_o,
  output logic                strobe_o,
  output logic                last_o
);

  localparam int DIV_W = $clog2(SHIFT_DIV + 1);
  localparam int BIT_W = $clog2(ID_WIDTH + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(SHIFT_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(ID_WIDTH - 1);

  logic [ID_WIDTH-1:0] shreg_q, shreg_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;

  assign strobe_o   = active_i && (div_cnt_q == DIV_MAX);
  assign last_o     = strobe_o && (bit_cnt_q == BIT_MAX);
  assign ser_data_o = shreg_q[ID_WIDTH-1];

  always_comb begin
    shreg_d   = shreg_q;
    div_cnt_d = div_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (load_i) begin
      shreg_d   = load_data_i;
      div_cnt_d = '0;
      bit_cnt_d = '0;
    end else if (active_i) begin
      if (strobe_o) begin
        div_cnt_d = '0;
        // Clearing on the final bit keeps ser_data_o low once the reader is idle.
        if (last_o) begin
          shreg_d   = '0;
          bit_cnt_d = '0;
        end else begin
          shreg_d   = {shreg_q[ID_WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shreg_q   <= '0;
      div_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      shreg_q   <= shreg_d;
      div_cnt_q <= div_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/user_id_reader.sv
// Double-samples the mask_rev ID word, flags a non-constant ID, presents it in parallel
// and streams it out MSB-first.
module user_id_reader
  import user_id_pkg::*;
#(
  parameter int ID_WIDTH   = DEFAULT_ID_WIDTH,
  parameter int SHIFT_DIV  = DEFAULT_SHIFT_DIV,
  parameter int SAMPLE_GAP = DEFAULT_SAMPLE_GAP
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [ID_WIDTH-1:0] mask_rev,
  user_id_reader_if.slave     rd
);

  localparam int GAP_W = $clog2(SAMPLE_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(SAMPLE_GAP - 1);

  state_e              state_q;
  logic [ID_WIDTH-1:0] s1_q;
  logic [GAP_W-1:0]    gap_cnt_q;
  logic                busy_q;
  logic                valid_q;
  logic [ID_WIDTH-1:0] data_q;
  logic                mismatch_q;

  logic gap_done;
  logic ser_data, ser_strobe, ser_last;

  assign gap_done = (state_q == ST_GAP) && (gap_cnt_q == GAP_MAX);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      s1_q       <= '0;
      gap_cnt_q  <= '0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      mismatch_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rd.req_i) begin
            s1_q      <= mask_rev;
            valid_q   <= 1'b0;
            busy_q    <= 1'b1;
            gap_cnt_q <= '0;
            state_q   <= ST_GAP;
          end
        end
        ST_GAP: begin
          // Second sample is the one reported and shifted, even when it disagrees with the first.
          if (gap_done) begin
            data_q     <= mask_rev;
            mismatch_q <= (s1_q != mask_rev);
            valid_q    <= 1'b1;
            gap_cnt_q  <= '0;
            state_q    <= ST_SHIFT;
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (ser_last) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  user_id_serializer #(
    .ID_WIDTH  (ID_WIDTH),
    .SHIFT_DIV (SHIFT_DIV)
  ) u_ser (
    .clk_i       (wb_clk_i),
    .rst_i       (wb_rst_i),
    .load_i      (gap_done),
    .load_data_i (mask_rev),
    .active_i    (state_q == ST_SHIFT),
    .ser_data_o  (ser_data),
    .strobe_o    (ser_strobe),
    .last_o      (ser_last)
  );

  assign rd.busy_o        = busy_q;
  assign rd.id_valid_o    = valid_q;
  assign rd.id_data_o     = data_q;
  assign rd.id_mismatch_o = mismatch_q;
  assign rd.ser_data_o    = ser_data;
  assign rd.ser_strobe_o  = ser_strobe;
  assign rd.ser_last_o    = ser_last;

endmodule

// File: tb/tb_user_id_reader.sv
// Directed bench for user_id_reader: default build plus a SHIFT_DIV=1 build.
module tb_user_id_reader;

  logic        clk;
  logic        rst0, rst1;
  logic [31:0] mask0, mask1;

  int n_checks = 0;
  int n_fail   = 0;

  user_id_reader_if #(.ID_WIDTH(32)) rd0 ();
  user_id_reader_if #(.ID_WIDTH(32)) rd1 ();

  user_id_reader #(.ID_WIDTH(32), .SHIFT_DIV(4), .SAMPLE_GAP(2)) u_dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst0),
    .mask_rev (mask0),
    .rd       (rd0)
  );

  user_id_reader #(.ID_WIDTH(32), .SHIFT_DIV(1), .SAMPLE_GAP(2)) u_dut1 (
    .wb_clk_i (clk),
    .wb_rst_i (rst1),
    .mask_rev (mask1),
    .rd       (rd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Results of one observed read on the default build
  logic [31:0] c_word, c_data2;
  logic        c_valid2, c_mis2;
  int          c_nstb, c_lasts, c_first, c_busy;
  bit          c_last_ok, c_spacing_ok, c_valid_drop, c_valid_early, c_ser_idle_ok;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called one sample after the accepting edge; follows the read until busy_o drops.
  task automatic collect(input bit extra_req);
    int cyc  = 0;
    int prev = -1;
    c_word = '0; c_data2 = '0; c_valid2 = 1'b0; c_mis2 = 1'b0;
    c_nstb = 0; c_lasts = 0; c_first = -1;
    c_last_ok = 1; c_spacing_ok = 1; c_valid_drop = 0; c_valid_early = 0; c_ser_idle_ok = 1;
    while (rd0.busy_o === 1'b1 && cyc < 400) begin
      if (extra_req) rd0.req_i = (cyc % 9 == 1);
      if (cyc < 2) begin
        if (rd0.ser_data_o !== 1'b0) c_ser_idle_ok = 0;
        if (rd0.id_valid_o !== 1'b0) c_valid_early = 1;
      end
      if (cyc == 2) begin
        c_valid2 = rd0.id_valid_o;
        c_data2  = rd0.id_data_o;
        c_mis2   = rd0.id_mismatch_o;
      end
      if (cyc >= 2 && rd0.id_valid_o !== 1'b1) c_valid_drop = 1;
      if (rd0.ser_strobe_o === 1'b1) begin
        c_word = {c_word[30:0], rd0.ser_data_o};
        c_nstb++;
        if (c_first < 0) c_first = cyc;
        else if (cyc - prev != 4) c_spacing_ok = 0;
        prev = cyc;
      end
      if (rd0.ser_last_o === 1'b1) begin
        c_lasts++;
        if (c_nstb != 32) c_last_ok = 0;
      end
      tick();
      cyc++;
    end
    rd0.req_i = 1'b0;
    c_busy = cyc;
  endtask

  task automatic check_read(input string tag, input logic [31:0] exp_id, input logic exp_mis);
    check({tag, "_busy_cycles"}, c_busy, 130);
    check({tag, "_valid_low_in_gap"}, c_valid_early, 0);
    check({tag, "_ser_zero_in_gap"}, c_ser_idle_ok, 1);
    check({tag, "_valid"}, c_valid2, 1'b1);
    check({tag, "_data"}, c_data2, exp_id);
    check({tag, "_mismatch"}, c_mis2, exp_mis);
    check({tag, "_valid_held"}, c_valid_drop, 0);
    check({tag, "_strobes"}, c_nstb, 32);
    check({tag, "_first_strobe"}, c_first, 5);
    check({tag, "_spacing"}, c_spacing_ok, 1);
    check({tag, "_serial_word"}, c_word, exp_id);
    check({tag, "_last_count"}, c_lasts, 1);
    check({tag, "_last_on_32"}, c_last_ok, 1);
    check({tag, "_ser_zero_after"}, rd0.ser_data_o, 1'b0);
    check({tag, "_valid_persists"}, rd0.id_valid_o, 1'b1);
    $display("read %s: id=%h mismatch=%0b serial=%h strobes=%0d busy=%0d",
             tag, c_data2, c_mis2, c_word, c_nstb, c_busy);
  endtask

  initial begin
    int stb;
    int run1, idle, run2, vlow, nstb_hh, i;
    int first1, last1, ones1, busy1, cyc;
    logic busy_s [300];
    logic valid_s[300];
    logic stb_s  [300];

    rst0 = 1'b1; rst1 = 1'b1;
    mask0 = '0; mask1 = '0;
    rd0.req_i = 1'b0; rd1.req_i = 1'b0;
    repeat (3) tick();
    rst0 = 1'b0; rst1 = 1'b0;
    tick();

    // Reset state
    check("rst_busy", rd0.busy_o, 1'b0);
    check("rst_valid", rd0.id_valid_o, 1'b0);
    check("rst_data", rd0.id_data_o, 32'h0);
    check("rst_mismatch", rd0.id_mismatch_o, 1'b0);
    check("rst_ser", {rd0.ser_data_o, rd0.ser_strobe_o, rd0.ser_last_o}, 3'b000);
    $display("reset: busy=%0b valid=%0b data=%h", rd0.busy_o, rd0.id_valid_o, rd0.id_data_o);

    // Basic read
    mask0 = 32'hA5C3_0F1E;
    rd0.req_i = 1'b1;
    tick();
    rd0.req_i = 1'b0;
    check("basic_busy_set", rd0.busy_o, 1'b1);
    collect(0);
    check_read("basic", 32'hA5C3_0F1E, 1'b0);

    // ID changes between the two samples
    mask0 = 32'h0;
    tick();
    rd0.req_i = 1'b1;
    tick();
    rd0.req_i = 1'b0;
    mask0 = 32'h0000_0001;
    collect(0);
    check_read("mismatch", 32'h0000_0001, 1'b1);

    // Extra requests during GAP and SHIFT are dropped
    mask0 = 32'h3C96_E107;
    tick();
    rd0.req_i = 1'b1;
    tick();
    rd0.req_i = 1'b0;
    collect(1);
    check_read("extra_req", 32'h3C96_E107, 1'b0);
    repeat (3) tick();
    check("extra_req_not_queued", rd0.busy_o, 1'b0);

    // Reset on the 10th strobe
    mask0 = 32'h1234_5678;
    rd0.req_i = 1'b1;
    tick();
    rd0.req_i = 1'b0;
    stb = 0;
    cyc = 0;
    while (stb < 10 && cyc < 100) begin
      if (rd0.ser_strobe_o === 1'b1) stb++;
      if (stb < 10) begin
        tick();
        cyc++;
      end
    end
    check("abort_reached_strobe10", stb, 10);
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    check("abort_busy", rd0.busy_o, 1'b0);
    check("abort_valid", rd0.id_valid_o, 1'b0);
    check("abort_data", rd0.id_data_o, 32'h0);
    check("abort_mismatch", rd0.id_mismatch_o, 1'b0);
    check("abort_ser", {rd0.ser_data_o, rd0.ser_strobe_o, rd0.ser_last_o}, 3'b000);
    stb = 0;
    for (int k = 0; k < 150; k++) begin
      if (rd0.ser_strobe_o !== 1'b0 || rd0.busy_o !== 1'b0) stb++;
      tick();
    end
    check("abort_quiet_after", stb, 0);
    $display("abort: reset at strobe 10, idle activity after=%0d", stb);
    mask0 = 32'h5A5A_F00F;
    rd0.req_i = 1'b1;
    tick();
    rd0.req_i = 1'b0;
    collect(0);
    check_read("after_abort", 32'h5A5A_F00F, 1'b0);

    // req_i held high: back-to-back sequences
    mask0 = 32'hC001_D00D;
    rd0.req_i = 1'b1;
    tick();
    for (int k = 0; k < 300; k++) begin
      busy_s[k]  = rd0.busy_o;
      valid_s[k] = rd0.id_valid_o;
      stb_s[k]   = rd0.ser_strobe_o;
      tick();
    end
    rd0.req_i = 1'b0;
    i = 0; run1 = 0; idle = 0; run2 = 0;
    while (i < 300 && busy_s[i] === 1'b1) begin run1++; i++; end
    while (i < 300 && busy_s[i] === 1'b0) begin idle++; i++; end
    while (i < 300 && busy_s[i] === 1'b1) begin run2++; i++; end
    vlow = 0; nstb_hh = 0;
    for (int k = 2; k <= 260; k++) if (valid_s[k] !== 1'b1) vlow++;
    for (int k = 0; k <= 260; k++) if (stb_s[k] === 1'b1) nstb_hh++;
    check("hold_run1", run1, 130);
    check("hold_idle_gap", idle, 1);
    check("hold_run2", run2, 130);
    check("hold_valid_drop_first", valid_s[0], 1'b0);
    check("hold_valid_low_cycles", vlow, 2);
    check("hold_strobes", nstb_hh, 64);
    $display("hold: run1=%0d idle=%0d run2=%0d valid_low=%0d strobes=%0d",
             run1, idle, run2, vlow, nstb_hh);
    cyc = 0;
    while (rd0.busy_o === 1'b1 && cyc < 200) begin tick(); cyc++; end
    check("hold_drains", rd0.busy_o, 1'b0);

    // SHIFT_DIV=1 build
    mask1 = 32'hFFFF_FFFF;
    rd1.req_i = 1'b1;
    tick();
    rd1.req_i = 1'b0;
    first1 = -1; last1 = -1; ones1 = 0; stb = 0; cyc = 0;
    while (rd1.busy_o === 1'b1 && cyc < 100) begin
      if (rd1.ser_strobe_o === 1'b1) begin
        stb++;
        if (first1 < 0) first1 = cyc;
        if (rd1.ser_data_o === 1'b1) ones1++;
      end
      if (rd1.ser_last_o === 1'b1) last1 = cyc;
      tick();
      cyc++;
    end
    busy1 = cyc;
    check("div1_strobes", stb, 32);
    check("div1_first", first1, 2);
    check("div1_last", last1, 33);
    check("div1_ones", ones1, 32);
    check("div1_busy", busy1, 34);
    check("div1_data", rd1.id_data_o, 32'hFFFF_FFFF);
    $display("div1: strobes=%0d first=%0d last=%0d ones=%0d busy=%0d",
             stb, first1, last1, ones1, busy1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
